// File: rtl/multi_frame_store_if.sv
// Bus bundle between the frame source / register slave and multi_frame_store.
// The master side drives capture control and read strobes; the slave side owns status and readout.
interface multi_frame_store_if #(
  parameter int FRAME_WIDTH = 256
);
  logic [FRAME_WIDTH-1:0] frame_in;
  logic                   frame_valid;
  logic                   trigger;
  logic                   abort;
  logic [7:0]             num_frames;
  logic [15:0]            decimation;
  logic [31:0]            status;
  logic [31:0]            frame_read;
  logic                   frame_read_rdStrobe;

  modport master (
    output frame_in, frame_valid, trigger, abort, num_frames, decimation, frame_read_rdStrobe,
    input  status, frame_read
  );

  modport slave (
    input  frame_in, frame_valid, trigger, abort, num_frames, decimation, frame_read_rdStrobe,
    output status, frame_read
  );
endinterface

// File: rtl/multi_frame_store.sv
// Multi-frame capture store: triggered capture of up to DEPTH decimated frames,
// read back as 32-bit chunks with auto-advancing chunk/frame pointers.
module multi_frame_store #(
  parameter int FRAME_WIDTH = 256,
  parameter int DEPTH       = 8
) (
  input logic                axi_clk,
  input logic                axi_resetn,
  multi_frame_store_if.slave bus
);
  localparam int NUM_CHUNKS = (FRAME_WIDTH + 31) / 32;
  localparam int PADW       = NUM_CHUNKS * 32;
  localparam int IDXW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH8     = 8'(DEPTH);
  localparam logic [7:0] LAST_CHUNK = 8'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_aborted;
  logic [7:0]             r_framesStored;
  logic [7:0]             r_rdFrame;
  logic [7:0]             r_rdChunk;
  logic [15:0]            r_decimCnt;
  logic [15:0]            r_decimation;
  logic [7:0]             r_target;
  logic [FRAME_WIDTH-1:0] r_mem [DEPTH];

  logic [7:0]             w_effN;
  logic                   w_store;
  logic [PADW-1:0]        w_padded;
  logic [PADW-1:0]        w_shifted;
  logic [31:0]            w_word;

  assign w_effN  = (bus.num_frames == 8'd0 || bus.num_frames > DEPTH8) ? DEPTH8 : bus.num_frames;
  // Abort takes priority over a coincident frame, so it also gates the storage write.
  assign w_store = (r_state == CAPTURE) && !bus.abort && bus.frame_valid && (r_decimCnt == 16'd0);

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state        <= IDLE;
      r_aborted      <= 1'b0;
      r_framesStored <= 8'd0;
      r_rdFrame      <= 8'd0;
      r_rdChunk      <= 8'd0;
      r_decimCnt     <= 16'd0;
      r_decimation   <= 16'd0;
      r_target       <= 8'd0;
    end else begin
      case (r_state)
        CAPTURE: begin
          if (bus.abort) begin
            r_state   <= DONE;
            r_aborted <= 1'b1;
          end else if (bus.frame_valid) begin
            if (r_decimCnt == 16'd0) begin
              r_framesStored <= r_framesStored + 8'd1;
              r_decimCnt     <= r_decimation;
              if (r_framesStored + 8'd1 == r_target) begin
                r_state <= DONE;
              end
            end else begin
              r_decimCnt <= r_decimCnt - 16'd1;
            end
          end
        end
        default: begin
          if (bus.trigger) begin
            r_state        <= CAPTURE;
            r_aborted      <= 1'b0;
            r_framesStored <= 8'd0;
            r_rdFrame      <= 8'd0;
            r_rdChunk      <= 8'd0;
            r_decimCnt     <= 16'd0;
            r_decimation   <= bus.decimation;
            r_target       <= w_effN;
          end else if (bus.frame_read_rdStrobe && r_framesStored != 8'd0) begin
            if (r_rdChunk == LAST_CHUNK) begin
              r_rdChunk <= 8'd0;
              r_rdFrame <= (r_rdFrame == r_framesStored - 8'd1) ? 8'd0 : r_rdFrame + 8'd1;
            end else begin
              r_rdChunk <= r_rdChunk + 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Frame storage is deliberately left out of reset; readout is gated until a frame lands.
  always_ff @(posedge axi_clk) begin
    if (w_store) begin
      r_mem[r_framesStored[IDXW-1:0]] <= bus.frame_in;
    end
  end

  always_comb begin
    w_padded                   = '0;
    w_padded[FRAME_WIDTH-1:0]  = r_mem[r_rdFrame[IDXW-1:0]];
    w_shifted                  = w_padded >> {r_rdChunk, 5'd0};
    w_word                     = w_shifted[31:0];
  end

  assign bus.frame_read = (r_state == CAPTURE || r_framesStored == 8'd0) ? 32'd0 : w_word;
  assign bus.status     = {r_rdChunk, r_rdFrame, r_framesStored, 5'd0, r_aborted, r_state};
endmodule

// File: tb/tb_multi_frame_store.sv
// Randomized bench for multi_frame_store against a queue-based reference model,
// preceded by directed capture/readout/abort/reset scenarios.
module tb_multi_frame_store;
  localparam int FW   = 40;
  localparam int DEP  = 4;
  localparam int NCH  = (FW + 31) / 32;

  logic axi_clk;
  logic axi_resetn;
  int   totalChecks;
  int   badChecks;

  multi_frame_store_if #(.FRAME_WIDTH(FW)) bus ();

  multi_frame_store #(.FRAME_WIDTH(FW), .DEPTH(DEP)) dut (
    .axi_clk   (axi_clk),
    .axi_resetn(axi_resetn),
    .bus       (bus)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Reference model: state as 0/1/2, captured frames as a queue, valids counted since trigger.
  int              mState;
  bit              mAborted;
  logic [FW-1:0]   mFrames [$];
  int              mTarget;
  int              mDec;
  int              mValidCnt;
  int              mRdFrame;
  int              mRdChunk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = 0; mAborted = 0; mFrames.delete();
    mTarget = 0; mDec = 0; mValidCnt = 0; mRdFrame = 0; mRdChunk = 0;
  endtask

  task automatic modelStep(input bit trig, input bit abrt, input int nf, input int dec,
                           input bit fv, input logic [FW-1:0] fd, input bit strobe);
    if (mState != 1) begin
      if (trig) begin
        mState = 1; mAborted = 0; mFrames.delete();
        mRdFrame = 0; mRdChunk = 0; mValidCnt = 0;
        mTarget = (nf == 0 || nf > DEP) ? DEP : nf;
        mDec = dec;
      end else if (strobe && mFrames.size() > 0) begin
        mRdChunk++;
        if (mRdChunk == NCH) begin
          mRdChunk = 0;
          mRdFrame = (mRdFrame + 1) % mFrames.size();
        end
      end
    end else if (abrt) begin
      mState = 2; mAborted = 1;
    end else if (fv) begin
      if (mValidCnt % (mDec + 1) == 0) begin
        mFrames.push_back(fd);
        if (mFrames.size() == mTarget) mState = 2;
      end
      mValidCnt++;
    end
  endtask

  function automatic logic [31:0] expStatus();
    logic [7:0] c, f, n;
    c = 8'(mRdChunk); f = 8'(mRdFrame); n = 8'(mFrames.size());
    return {c, f, n, 5'd0, mAborted, 2'(mState)};
  endfunction

  function automatic logic [31:0] expRead();
    logic [NCH*32-1:0] padded;
    if (mState == 1 || mFrames.size() == 0) return 32'd0;
    padded = '0;
    padded[FW-1:0] = mFrames[mRdFrame];
    padded = padded >> (32 * mRdChunk);
    return padded[31:0];
  endfunction

  task automatic applyStimulus(input bit trig, input bit abrt, input logic [7:0] nf, input logic [15:0] dec,
                               input bit fv, input logic [FW-1:0] fd, input bit strobe);
    bus.trigger = trig; bus.abort = abrt; bus.num_frames = nf; bus.decimation = dec;
    bus.frame_valid = fv; bus.frame_in = fd; bus.frame_read_rdStrobe = strobe;
    @(posedge axi_clk);
    modelStep(trig, abrt, int'(nf), int'(dec), fv, fd, strobe);
    #1;
    bus.trigger = 0; bus.abort = 0; bus.frame_valid = 0; bus.frame_read_rdStrobe = 0;
    checkOutput("status", bus.status, expStatus());
    checkOutput("frame_read", bus.frame_read, expRead());
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 0);
  endtask

  task automatic doReset();
    axi_resetn = 1'b0;
    #2;
    modelReset();
    checkOutput("reset_status", bus.status, 32'd0);
    checkOutput("reset_read", bus.frame_read, 32'd0);
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    @(posedge axi_clk);
    #1;
  endtask

  logic [FW-1:0] tpFrames [4];

  initial begin
    totalChecks = 0; badChecks = 0;
    bus.trigger = 0; bus.abort = 0; bus.num_frames = 0; bus.decimation = 0;
    bus.frame_valid = 0; bus.frame_in = '0; bus.frame_read_rdStrobe = 0;
    axi_resetn = 1'b1;
    modelReset();
    #3;
    doReset();

    // Capture three of four frames; a valid coincident with the trigger is dropped.
    tpFrames[0] = 40'hA1_11223344; tpFrames[1] = 40'hB2_55667788;
    tpFrames[2] = 40'hC3_99AABBCC; tpFrames[3] = 40'hD4_DDEEFF00;
    applyStimulus(1, 0, 8'd3, 16'd0, 1, 40'hEE_EEEEEEEE, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'd0, 16'd0, 1, tpFrames[i], 0);
    checkOutput("tp1_done", {16'd0, bus.status[15:0]}, 32'h0000_0302);
    checkOutput("tp1_word0", bus.frame_read, 32'h1122_3344);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 1);
    checkOutput("tp2_wrap", bus.frame_read, 32'h1122_3344);
    applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 1);
    checkOutput("tp2_hi", bus.frame_read, 32'h0000_00A1);
    checkOutput("tp2_ptr", {16'd0, bus.status[31:16]}, 32'h0000_0100);

    // Decimation 2, two frames from values 1..7.
    applyStimulus(1, 0, 8'd2, 16'd2, 0, '0, 0);
    for (int v = 1; v <= 7; v++) applyStimulus(0, 0, 8'd0, 16'd0, 1, 40'(v), 0);
    checkOutput("tp3_first", bus.frame_read, 32'd1);
    applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 1);
    applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 1);
    checkOutput("tp3_second", bus.frame_read, 32'd4);

    // num_frames 0 and 9 both saturate at DEPTH.
    foreach (tpFrames[k]) begin end
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1, 0, (r == 0) ? 8'd0 : 8'd9, 16'd0, 0, '0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'd0, 16'd0, 1, {8'(r), 32'(i)}, 0);
      checkOutput("tp4_count", {24'd0, bus.status[15:8]}, 32'd4);
    end

    // Abort after two frames with a coincident valid.
    applyStimulus(1, 0, 8'd4, 16'd0, 0, '0, 0);
    applyStimulus(0, 0, 8'd0, 16'd0, 1, 40'h11, 0);
    applyStimulus(0, 0, 8'd0, 16'd0, 1, 40'h22, 0);
    applyStimulus(0, 1, 8'd0, 16'd0, 1, 40'h33, 0);
    checkOutput("tp5_abort", {16'd0, bus.status[15:0]}, 32'h0000_0206);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 1);

    // Reset mid-capture, then a retrigger during capture is ignored.
    applyStimulus(1, 0, 8'd3, 16'd0, 0, '0, 0);
    applyStimulus(0, 0, 8'd0, 16'd0, 1, 40'h44, 0);
    doReset();
    applyStimulus(0, 0, 8'd0, 16'd0, 0, '0, 1);
    applyStimulus(1, 0, 8'd3, 16'd0, 0, '0, 0);
    applyStimulus(0, 0, 8'd0, 16'd0, 1, 40'h55, 0);
    applyStimulus(1, 0, 8'd1, 16'd0, 0, '0, 0);
    applyStimulus(0, 0, 8'd0, 16'd0, 1, 40'h66, 0);
    checkOutput("tp6_retrig", {24'd0, bus.status[15:8]}, 32'd2);
    idleCycle();

    // Random traffic with occasional resets.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 450 == 449) doReset();
      applyStimulus(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 3),
                    8'($urandom_range(0, 6)), 16'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 45), {8'($urandom), 32'($urandom)},
                    ($urandom_range(0, 99) < 35));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
